// File: rtl/lpf_mavg_pkg.sv
// Shared definitions for the moving-average filter: window depth, accumulator
// width and the legal LOG2_DEPTH range.
package lpf_mavg_pkg;

   localparam int LOG2_DEPTH_MIN = 1;
   localparam int LOG2_DEPTH_MAX = 8;

   function automatic int depth_of(input int log2_depth);
      return 1 << log2_depth;
   endfunction

   // A sum of 2^L W-bit signed samples always fits in W+L signed bits.
   function automatic int acc_w(input int w, input int log2_depth);
      return w + log2_depth;
   endfunction

endpackage

// File: rtl/lpf_delay_line.sv
// Circular DEPTH x W sample store. o_old is the entry about to be overwritten,
// i.e. the sample leaving the window on the next write.
module lpf_delay_line
   import lpf_mavg_pkg::*;
#(
   parameter int W          = 32,
   parameter int LOG2_DEPTH = 2
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_clear,
   input  logic         i_we,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_old
);

   localparam int DEPTH = depth_of(LOG2_DEPTH);

   logic [DEPTH-1:0][W-1:0] line_q, line_d;
   logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;

   assign o_old = line_q[wr_ptr_q];

   always_comb begin
      line_d   = line_q;
      wr_ptr_d = wr_ptr_q;
      if (i_clear) begin
         line_d   = '0;
         wr_ptr_d = '0;
      end else if (i_we) begin
         line_d[wr_ptr_q] = i_data;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         line_q   <= '0;
         wr_ptr_q <= '0;
      end else begin
         line_q   <= line_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

endmodule

// File: rtl/lpf_mavg.sv
// Running-sum moving-average filter over 2^LOG2_DEPTH signed samples.
// Define LPF_MAVG_ROUND_EN for round-half-up scaling; default is floor.
module lpf_mavg
   import lpf_mavg_pkg::*;
#(
   parameter int W          = 32,
   parameter int LOG2_DEPTH = 2
) (
   input  logic         i_clock,
   input  logic         i_RESET,
   input  logic         i_clear,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_mean,
   output logic         o_full
);

   localparam int AW    = acc_w(W, LOG2_DEPTH);
   localparam int DEPTH = depth_of(LOG2_DEPTH);
   localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(DEPTH);

   generate
      if (LOG2_DEPTH < LOG2_DEPTH_MIN || LOG2_DEPTH > LOG2_DEPTH_MAX) begin : g_bad_depth
         $error("lpf_mavg: LOG2_DEPTH out of range 1..8");
      end
   endgenerate

   logic [W-1:0]          old;
   logic [AW-1:0]         acc_q, acc_d, next_acc;
   logic [LOG2_DEPTH:0]   cnt_q, cnt_d;
   logic [W-1:0]          mean_q, mean_d;
   logic                  valid_q, valid_d;
   logic                  full_q, full_d;
   logic [W-1:0]          scaled;

   lpf_delay_line #(.W(W), .LOG2_DEPTH(LOG2_DEPTH)) u_line (
      .i_clock (i_clock),
      .i_reset (i_RESET),
      .i_clear (i_clear),
      .i_we    (i_valid),
      .i_data  (i_data),
      .o_old   (old)
   );

   // Modular W+L-bit add/sub is exact because the final sum always fits.
   assign next_acc = acc_q + {{LOG2_DEPTH{i_data[W-1]}}, i_data}
                           - {{LOG2_DEPTH{old[W-1]}}, old};

`ifdef LPF_MAVG_ROUND_EN
   localparam logic [AW:0] RND = (AW+1)'(1) << (LOG2_DEPTH-1);
   logic [AW:0] rnd_sum;
   assign rnd_sum = {next_acc[AW-1], next_acc} + RND;
   assign scaled  = rnd_sum[AW-1:LOG2_DEPTH];
`else
   // Selecting bits [AW-1:L] is the arithmetic shift truncated to W bits.
   assign scaled = next_acc[AW-1:LOG2_DEPTH];
`endif

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mean_d  = mean_q;
      full_d  = full_q;
      valid_d = 1'b0;
      if (i_clear) begin
         acc_d  = '0;
         cnt_d  = '0;
         mean_d = '0;
         full_d = 1'b0;
      end else if (i_valid) begin
         acc_d   = next_acc;
         mean_d  = scaled;
         valid_d = 1'b1;
         if (cnt_q != DEPTH_C) cnt_d = cnt_q + 1'b1;
         full_d  = (cnt_d == DEPTH_C);
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_RESET) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         mean_q  <= '0;
         valid_q <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mean_q  <= mean_d;
         valid_q <= valid_d;
         full_q  <= full_d;
      end
   end

   assign o_valid = valid_q;
   assign o_mean  = mean_q;
   assign o_full  = full_q;

endmodule

// File: tb/tb_lpf_mavg.sv
// Directed bench for lpf_mavg: window-4 and window-32 builds on a shared stream.
module tb_lpf_mavg;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        clr  = 1'b0;
   logic        vld  = 1'b0;
   logic [31:0] din  = '0;

   logic        ov4, of4, ov32, of32;
   logic [31:0] om4, om32;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lpf_mavg #(.W(32), .LOG2_DEPTH(2)) dut4 (
      .i_clock(clk), .i_RESET(rst), .i_clear(clr), .i_valid(vld), .i_data(din),
      .o_valid(ov4), .o_mean(om4), .o_full(of4)
   );

   lpf_mavg #(.W(32), .LOG2_DEPTH(5)) dut32 (
      .i_clock(clk), .i_RESET(rst), .i_clear(clr), .i_valid(vld), .i_data(din),
      .o_valid(ov32), .o_mean(om32), .o_full(of32)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input logic r, input logic c, input logic v, input logic [31:0] d);
      rst = r; clr = c; vld = v; din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string tag, input logic v, input logic [31:0] m, input logic f);
      chk({tag, ".valid"}, {31'b0, ov4}, {31'b0, v});
      chk({tag, ".mean"},  om4, m);
      chk({tag, ".full"},  {31'b0, of4}, {31'b0, f});
   endtask

   logic [31:0] exp_neg6 [4];
   logic [31:0] exp_pad;
   logic [31:0] exp_ext [8];

   initial begin
`ifdef LPF_MAVG_ROUND_EN
      exp_neg6 = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFA};
      exp_pad  = 32'hFFFFFFFF;
      exp_ext  = '{32'h3FFFFFFF, 32'h00000000, 32'hC0000000, 32'h80000000,
                   32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
`else
      exp_neg6 = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'hFFFFFFFA};
      exp_pad  = 32'hFFFFFFFE;
      exp_ext  = '{32'h3FFFFFFF, 32'hFFFFFFFF, 32'hBFFFFFFF, 32'h80000000,
                   32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
`endif

      // reset state
      cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 32'd77);
      chk4("reset", 0, 0, 0);

      // constant 100 ramp and steady state
      begin
         logic [31:0] exp100 [6] = '{25, 50, 75, 100, 100, 100};
         logic        expf   [6] = '{0, 0, 0, 1, 1, 1};
         for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 32'd100);
            chk4($sformatf("c100[%0d]", i), 1, exp100[i], expf[i]);
         end
      end
      cyc(0, 0, 0, 32'd555);
      chk4("gap_hold", 0, 100, 1);

      // clear together with valid wins
      cyc(0, 1, 1, 32'd40);
      chk4("clear", 0, 0, 0);
      cyc(0, 0, 1, 32'd40);
      chk4("post_clear", 1, 10, 0);

      // constant -6, then zero window and the -6,0,0,0 pattern
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 32'hFFFFFFFA);
         chk4($sformatf("neg6[%0d]", i), 1, exp_neg6[i], i == 3);
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
      chk4("zero_win", 1, 0, 1);
      cyc(0, 0, 1, 32'hFFFFFFFA);
      chk4("pad[0]", 1, exp_pad, 1);
      for (int i = 1; i < 4; i++) begin
         cyc(0, 0, 1, 0);
         chk4($sformatf("pad[%0d]", i), 1, exp_pad, 1);
      end

      // extremes: no wrap at any output
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 32'h7FFFFFFF);
      chk4("max", 1, 32'h7FFFFFFF, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 1, 32'h80000000);
         chk($sformatf("min[%0d]", i), om4, exp_ext[i]);
      end

      // gapped input: valids at offsets 0,3,4,9
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 32'd4);  chk4("gap_v0", 1, 1, 0);
      cyc(0, 0, 0, 0);      chk4("gap_i1", 0, 1, 0);
      cyc(0, 0, 0, 0);      chk4("gap_i2", 0, 1, 0);
      cyc(0, 0, 1, 32'd8);  chk4("gap_v3", 1, 3, 0);
      cyc(0, 0, 1, 32'd12); chk4("gap_v4", 1, 6, 0);
      for (int i = 5; i < 9; i++) begin
         cyc(0, 0, 0, 0);
         chk4($sformatf("gap_i%0d", i), 0, 6, 0);
      end
      cyc(0, 0, 1, 32'd16); chk4("gap_v9", 1, 10, 1);

      // reset mid-stream with valid high drops the sample
      cyc(0, 0, 1, 32'd100);
      cyc(1, 0, 1, 32'd100);
      chk4("mid_reset", 0, 0, 0);
      cyc(0, 0, 1, 32'd100);
      chk4("restart", 1, 25, 0);

      // window-32 build
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         cyc(0, 0, 1, 32'd1000);
         if (i == 30) chk("d32_full31", {31'b0, of32}, 32'd0);
      end
      chk("d32_valid", {31'b0, ov32}, 32'd1);
      chk("d32_mean",  om32, 32'd1000);
      chk("d32_full",  {31'b0, of32}, 32'd1);
      cyc(0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
